gen_scheduler: RTL and testbench

GEN_SCHEDULER -- requirements
Module: gen_scheduler

---
 rtl/gen_scheduler.sv | 147 ++++++++++++++
 tb/tb_gen_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_scheduler.sv
// gen_scheduler: paces life-engine generations against VGA frame ticks.
//
// While running, a generation is launched every NEW_ITER_PERIOD frames. The
// engine reads buffer buf_sel and writes !buf_sel. The buffers are swapped on
// the first frame tick after the engine reports done, so the display only ever
// changes between frames.
//
// Optional feature macro: GOL_SINGLE_STEP_EN adds step_req. With it, a paused
// scheduler can run a single generation on request.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   frame_tick  1-cycle pulse at start of vertical blanking
//   run_toggle  1-cycle pulse, toggles run/pause and clears overrun
//   step_req    1-cycle pulse, single-generation request (GOL_SINGLE_STEP_EN only)
//   eng_start   1-cycle pulse launching the engine
//   eng_done    1-cycle pulse, engine finished writing the back buffer
//   buf_sel     front buffer index
//   gen_count   completed generations, wraps modulo 2^GEN_W
//   running     current go flag
//   overrun     sticky, a launch tick arrived while a generation was in flight
module gen_scheduler #(
    parameter int unsigned NEW_ITER_PERIOD = 60,
    parameter int unsigned GEN_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             run_toggle,
`ifdef GOL_SINGLE_STEP_EN
    input  logic             step_req,
`endif
    output logic             eng_start,
    input  logic             eng_done,
    output logic             buf_sel,
    output logic [GEN_W-1:0] gen_count,
    output logic             running,
    output logic             overrun
);

    localparam int unsigned CNT_W = $clog2(NEW_ITER_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NEW_ITER_PERIOD - 1);

    typedef enum logic [2:0] {StIdle, StCount, StStart, StBusy, StSwap} state_e;

    state_e             state_q, state_d;
    logic               go_q, go_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               buf_sel_q, buf_sel_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic               overrun_q, overrun_d;
    // Set on the first edge after reset release. Nothing else moves until then,
    // so the earliest state change is on the second edge.
    logic               ready_q;
    logic               launch;

    always_comb begin
        state_d   = state_q;
        go_d      = go_q;
        cnt_d     = cnt_q;
        buf_sel_d = buf_sel_q;
        gen_d     = gen_q;
        overrun_d = overrun_q;
        launch    = 1'b0;

        if (ready_q) begin
            go_d = go_q ^ run_toggle;
            // A tick in the same cycle that go falls is swallowed by the clear.
            launch = go_q & ~run_toggle & frame_tick & (cnt_q == CNT_MAX);

            if (go_q && run_toggle) begin
                cnt_d = '0;
            end else if (go_q && frame_tick) begin
                cnt_d = launch ? '0 : cnt_q + CNT_W'(1);
            end

            if (run_toggle) begin
                overrun_d = 1'b0;
            end else if (launch && (state_q != StIdle) && (state_q != StCount)) begin
                overrun_d = 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (go_q) begin
                        state_d = StCount;
                    end
`ifdef GOL_SINGLE_STEP_EN
                    else if (step_req && !run_toggle) begin
                        state_d = StStart;
                    end
`endif
                end
                StCount: begin
                    if (!go_q) begin
                        state_d = StIdle;
                    end else if (launch) begin
                        state_d = StStart;
                    end
                end
                StStart: state_d = StBusy;
                StBusy: begin
                    if (eng_done) begin
                        state_d = StSwap;
                    end
                end
                StSwap: begin
                    // Entered the cycle after eng_done, so any tick here is strictly later.
                    if (frame_tick) begin
                        buf_sel_d = ~buf_sel_q;
                        gen_d     = gen_q + GEN_W'(1);
                        state_d   = go_d ? StCount : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            go_q      <= 1'b0;
            cnt_q     <= '0;
            buf_sel_q <= 1'b0;
            gen_q     <= '0;
            overrun_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_q      <= go_d;
            cnt_q     <= cnt_d;
            buf_sel_q <= buf_sel_d;
            gen_q     <= gen_d;
            overrun_q <= overrun_d;
            ready_q   <= 1'b1;
        end
    end

    assign eng_start = (state_q == StStart);
    assign buf_sel   = buf_sel_q;
    assign gen_count = gen_q;
    assign running   = go_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_gen_scheduler.sv
module tb_gen_scheduler;

    localparam int unsigned P = 4;
    localparam int unsigned GW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_tick = 1'b0;
    logic          run_toggle = 1'b0;
    logic          step_req = 1'b0;
    logic          eng_done = 1'b0;
    logic          eng_start;
    logic          buf_sel;
    logic [GW-1:0] gen_count;
    logic          running;
    logic          overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int starts   = 0;

    gen_scheduler #(
        .NEW_ITER_PERIOD (P),
        .GEN_W           (GW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .run_toggle (run_toggle),
`ifdef GOL_SINGLE_STEP_EN
        .step_req   (step_req),
`endif
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .buf_sel    (buf_sel),
        .gen_count  (gen_count),
        .running    (running),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && eng_start) starts <= starts + 1;
    end

    typedef struct {
        logic ft;
        logic rt;
        logic ed;
        logic st;
        logic bs;
        int   gen;
        logic run;
        logic ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ft, rt, ed, st, bs, input int gen, input logic run, ov);
        vec_t v;
        v.ft = ft; v.rt = rt; v.ed = ed; v.st = st; v.bs = bs;
        v.gen = gen; v.run = run; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic ft, rt, ed, sr);
        frame_tick = ft; run_toggle = rt; eng_done = ed; step_req = sr;
        @(posedge clk);
        #1;
        frame_tick = 1'b0; run_toggle = 1'b0; eng_done = 1'b0; step_req = 1'b0;
    endtask

    task automatic tick_to_launch();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (eng_start) seen = 1'b1;
        end
        chk("launch_seen", int'(seen), 1);
    endtask

    task automatic run_gen(input int exp_gen, input logic exp_buf);
        tick_to_launch();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_gen_count", int'(gen_count), exp_gen);
        chk("run_gen_buf", int'(buf_sel), int'(exp_buf));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;

        rst_n = 1'b0;
        #1;
        chk("reset_outputs", int'({eng_start, buf_sel, running, overrun}), 0);
        chk("reset_gen", int'(gen_count), 0);
        do_reset();

        // ft rt ed | start buf gen run ov
        add(0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 2, 1, 0);
        add(1, 0, 0, 0, 0, 2, 1, 0);
        add(1, 0, 0, 0, 0, 2, 1, 0);
        add(1, 0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 0, 2, 1, 0);  // done during START is ignored
        add(0, 0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 1, 0, 0, 2, 1, 0);
        add(1, 0, 0, 0, 1, 3, 1, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].ft, vecs[i].rt, vecs[i].ed, 1'b0);
            n_checks++;
            if (eng_start === vecs[i].st && buf_sel === vecs[i].bs &&
                int'(gen_count) == vecs[i].gen && running === vecs[i].run &&
                overrun === vecs[i].ov) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: got st=%b buf=%b gen=%0d run=%b ov=%b expected st=%b buf=%b gen=%0d run=%b ov=%b",
                         i, eng_start, buf_sel, gen_count, running, overrun,
                         vecs[i].st, vecs[i].bs, vecs[i].gen, vecs[i].run, vecs[i].ov);
            end
        end

        // Overrun: engine stalls across a full launch period.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("ovr_launch", int'(eng_start), 1);
        base = starts + 1;
        for (int t = 1; t <= 5; t++) begin
            cyc(1, 0, 0, 0);
            if (t == 3) chk("ovr_before_wrap", int'(overrun), 0);
            if (t == 4) chk("ovr_on_wrap", int'(overrun), 1);
            cyc(0, 0, 0, 0);
        end
        chk("ovr_single_start", starts, base);
        chk("ovr_still_set", int'(overrun), 1);
        // Pause while BUSY: clears overrun, generation still completes.
        cyc(0, 1, 0, 0);
        chk("pause_clears_ovr", int'(overrun), 0);
        chk("pause_running", int'(running), 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("pause_swap_gen", int'(gen_count), 4);
        chk("pause_swap_buf", int'(buf_sel), 0);
        for (int t = 0; t < 8; t++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk("pause_no_start", starts, base);
        chk("pause_idle_running", int'(running), 0);

        // eng_done coincident with a frame tick must not swap on that tick.
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        tick_to_launch();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 0);
        chk("coinc_no_swap_buf", int'(buf_sel), 0);
        chk("coinc_no_swap_gen", int'(gen_count), 4);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("coinc_next_tick_buf", int'(buf_sel), 1);
        chk("coinc_next_tick_gen", int'(gen_count), 5);

        // Reach BUSY with buf_sel=1, gen_count=7, then reset mid-generation.
        run_gen(6, 1'b0);
        run_gen(7, 1'b1);
        tick_to_launch();
        cyc(0, 0, 0, 0);
        chk("pre_reset_gen", int'(gen_count), 7);
        chk("pre_reset_buf", int'(buf_sel), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", int'({eng_start, buf_sel, running, overrun}), 0);
        chk("async_reset_gen", int'(gen_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        base = starts;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("late_done_buf", int'(buf_sel), 0);
        chk("late_done_gen", int'(gen_count), 0);
        chk("late_done_start", starts, base);

`ifdef GOL_SINGLE_STEP_EN
        cyc(0, 0, 0, 1);
        chk("step_start", int'(eng_start), 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("step_gen", int'(gen_count), 1);
        chk("step_buf", int'(buf_sel), 1);
        cyc(0, 0, 0, 0);
        chk("step_back_idle", int'({eng_start, running}), 0);
        base = starts;
        cyc(0, 1, 0, 1);
        chk("step_toggle_wins", int'({eng_start, running}), 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("step_while_running", starts, base);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
